coffee_vending_core: RTL and testbench

//  Parametrised successor to the coffee vending controller. Takes N_PROD products, each

---
 rtl/coffee_vending_core.sv | 109 ++++++++++
 tb/tb_coffee_vending_core.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/coffee_vending_core.sv
// coffee_vending_core: credit tracking, product selection and timed ingredient dispense for N_PROD products.
// Optional AUTO_CHANGE_EN: refund the residual credit automatically when a dispense completes.
module coffee_vending_core #(
  parameter int CREDIT_W = 5,
  parameter int N_PROD = 3,
  parameter int COIN_VALUE = 1,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {5'd15, 5'd12, 5'd10},
  parameter logic [N_PROD*4-1:0] RECIPES = {4'hF, 4'h7, 4'h3},
  parameter int DISP_CYCLES = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Input_Money,
  input  logic                Req_Change,
  input  logic [N_PROD-1:0]   Click,
  output logic [CREDIT_W-1:0] Money,
  output logic [CREDIT_W-1:0] Change,
  output logic                Change_Valid,
  output logic                Water,
  output logic                Coffee,
  output logic                Cream,
  output logic                Sugar,
  output logic                Busy,
  output logic                Insufficient
);
  localparam int MAX_CREDIT = 2**CREDIT_W - 1;
  localparam int CW = DISP_CYCLES > 1 ? $clog2(DISP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, WATER, COFFEE, CREAM, SUGAR, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] rec, rec_n, rec_sel;
  logic [CREDIT_W-1:0] price, paid, base, money_n, change_n;
  logic hit, buy, refund, short_n;
  int sum;
  // Ingredient state for mask bit j is WATER+j; returns the first enabled one at or after bit s.
  function automatic state_t first_from(input logic [3:0] r, input int s);
    first_from = DONE;
    for (int j = 3; j >= 0; j--)
      if (j >= s && r[j]) first_from = state_t'(3'(j + 1));
  endfunction
  always_comb begin
    price = '0;
    rec_sel = '0;
    for (int i = N_PROD - 1; i >= 0; i--)
      if (Click[i]) begin
        price = PRICES[i*CREDIT_W +: CREDIT_W];
        rec_sel = RECIPES[i*4 +: 4];
      end
  end
  always_comb begin
    hit = |Click;
    state_n = state;
    cnt_n = cnt;
    rec_n = rec;
    buy = 1'b0;
    short_n = 1'b0;
    if (state == IDLE) begin
      buy = hit && Money >= price;
      short_n = hit && Money < price;
      rec_n = buy ? rec_sel : rec;
      state_n = buy ? first_from(rec_sel, 0) : IDLE;
      cnt_n = '0;
    end else if (state == DONE) begin
      state_n = IDLE;
    end else begin
      state_n = cnt == CW'(DISP_CYCLES - 1) ? first_from(rec, int'(state)) : state;
      cnt_n = cnt == CW'(DISP_CYCLES - 1) ? '0 : cnt + CW'(1);
    end
    paid = buy ? Money - price : Money;
`ifdef AUTO_CHANGE_EN
    refund = (state == IDLE && Req_Change && !hit) || state_n == DONE;
`else
    refund = state == IDLE && Req_Change && !hit;
`endif
    change_n = refund ? paid : '0;
    base = refund ? '0 : paid;
    sum = int'(base) + (Input_Money ? COIN_VALUE : 0);
    money_n = sum > MAX_CREDIT ? CREDIT_W'(MAX_CREDIT) : CREDIT_W'(sum);
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      rec <= '0;
      Money <= '0;
      Change <= '0;
      Change_Valid <= 1'b0;
      Water <= 1'b0;
      Coffee <= 1'b0;
      Cream <= 1'b0;
      Sugar <= 1'b0;
      Busy <= 1'b0;
      Insufficient <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rec <= rec_n;
      Money <= money_n;
      Change <= change_n;
      Change_Valid <= refund;
      Water <= state_n == WATER;
      Coffee <= state_n == COFFEE;
      Cream <= state_n == CREAM;
      Sugar <= state_n == SUGAR;
      Busy <= state_n != IDLE;
      Insufficient <= short_n;
    end
  end
endmodule

// File: tb/tb_coffee_vending_core.sv
// tb_coffee_vending_core: vector table driven through a scoreboard queue, plus async-reset sequences.
module tb_coffee_vending_core;
`ifdef AUTO_CHANGE_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif
  logic clk, rst, coin, req;
  logic [2:0] click;
  logic [4:0] money, change;
  logic change_valid, water, coffee, cream, sugar, busy, insufficient;
  int total = 0, passed = 0;
  typedef struct {
    string name;
    bit coin, req;
    logic [2:0] click;
    int n;
    bit each;
    logic [16:0] exp;
  } vec_t;
  typedef struct {
    string name;
    bit chk;
    logic [16:0] exp;
  } sb_t;
  vec_t vecs[$];
  sb_t exp_q[$];
  wire [16:0] act = {money, change, change_valid, sugar, cream, coffee, water, busy, insufficient};
  coffee_vending_core dut (
    .Clock(clk), .Reset(rst), .Input_Money(coin), .Req_Change(req), .Click(click),
    .Money(money), .Change(change), .Change_Valid(change_valid),
    .Water(water), .Coffee(coffee), .Cream(cream), .Sugar(sugar),
    .Busy(busy), .Insufficient(insufficient)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // valve mask v is {Sugar,Cream,Coffee,Water}
  function automatic logic [16:0] o(int m, int ch, bit cv, logic [3:0] v, bit b, bit ins);
    return {5'(m), 5'(ch), cv, v, b, ins};
  endfunction
  function automatic void add(string nm, bit c, bit r, logic [2:0] k, int n, bit each, logic [16:0] e);
    vec_t v;
    v.name = nm; v.coin = c; v.req = r; v.click = k; v.n = n; v.each = each; v.exp = e;
    vecs.push_back(v);
  endfunction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      sb_t s;
      s = exp_q.pop_front();
      if (s.chk) begin
        total++;
        if (act !== s.exp)
          $display("FAIL %s: got=%05h want=%05h (Money got %0d want %0d)", s.name, act, s.exp, act[16:12], s.exp[16:12]);
        else passed++;
      end
    end
  end
  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      for (int k = 0; k < vecs[i].n; k++) begin
        sb_t s;
        coin = vecs[i].coin; req = vecs[i].req; click = vecs[i].click;
        @(posedge clk);
        s.name = vecs[i].name; s.chk = vecs[i].each || k == vecs[i].n - 1; s.exp = vecs[i].exp;
        exp_q.push_back(s);
        @(negedge clk);
      end
    coin = 0; req = 0; click = '0;
  endtask
  task automatic chk0(input string nm);
    total++;
    if (act !== 17'h0) $display("FAIL %s: got=%05h want=00000", nm, act);
    else passed++;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int seg_a, m3, p;
    add("coin12", 1, 0, 3'b000, 12, 0, o(12, 0, 0, 4'h0, 0, 0));
    add("buy0", 0, 0, 3'b001, 1, 1, o(2, 0, 0, 4'h1, 1, 0));
    add("water", 0, 0, 3'b000, 3, 1, o(2, 0, 0, 4'h1, 1, 0));
    add("coffee", 0, 0, 3'b000, 4, 1, o(2, 0, 0, 4'h2, 1, 0));
    add("done", 0, 0, 3'b000, 1, 1, o(2, 0, 0, 4'h0, 1, 0));
    add("idle", 0, 0, 3'b000, 1, 1, o(2, 0, 0, 4'h0, 0, 0));
    add("insuf2", 0, 0, 3'b100, 1, 1, o(2, 0, 0, 4'h0, 0, 1));
    add("insuf_low", 0, 0, 3'b110, 1, 1, o(2, 0, 0, 4'h0, 0, 1));
    add("post_ins", 0, 0, 3'b000, 1, 1, o(2, 0, 0, 4'h0, 0, 0));
    add("refund2", 0, 1, 3'b000, 1, 1, o(0, 2, 1, 4'h0, 0, 0));
    add("post_ref", 0, 0, 3'b000, 1, 1, o(0, 0, 0, 4'h0, 0, 0));
    add("coin40", 1, 0, 3'b000, 40, 0, o(31, 0, 0, 4'h0, 0, 0));
    add("sat", 1, 0, 3'b000, 1, 1, o(31, 0, 0, 4'h0, 0, 0));
    add("refund31", 0, 1, 3'b000, 1, 1, o(0, 31, 1, 4'h0, 0, 0));
    add("ref_coin", 1, 1, 3'b000, 1, 1, o(1, 0, 1, 4'h0, 0, 0));
    add("coin19", 1, 0, 3'b000, 19, 0, o(20, 0, 0, 4'h0, 0, 0));
    add("buy1", 0, 0, 3'b110, 1, 1, o(8, 0, 0, 4'h1, 1, 0));
    add("water1", 0, 0, 3'b000, 3, 1, o(8, 0, 0, 4'h1, 1, 0));
    add("coffee1", 0, 0, 3'b000, 4, 1, o(8, 0, 0, 4'h2, 1, 0));
    add("cream1", 0, 0, 3'b000, 2, 1, o(8, 0, 0, 4'h4, 1, 0));
    seg_a = vecs.size();
    add("coin20", 1, 0, 3'b000, 20, 0, o(20, 0, 0, 4'h0, 0, 0));
    add("buy0b", 0, 0, 3'b001, 1, 1, o(10, 0, 0, 4'h1, 1, 0));
    add("water2", 0, 0, 3'b000, 3, 1, o(10, 0, 0, 4'h1, 1, 0));
    add("cof_req", 0, 1, 3'b010, 4, 1, o(10, 0, 0, 4'h2, 1, 0));
    add("done2", 0, 0, 3'b000, 1, 1, o(AC ? 0 : 10, AC ? 10 : 0, AC, 4'h0, 1, 0));
    add("idle2", 0, 0, 3'b000, 1, 1, o(AC ? 0 : 10, 0, 0, 4'h0, 0, 0));
    add("refund10", 0, 1, 3'b000, 1, 1, o(0, AC ? 0 : 10, 1, 4'h0, 0, 0));
    add("coin10", 1, 0, 3'b000, 10, 0, o(10, 0, 0, 4'h0, 0, 0));
    add("exact_req", 0, 1, 3'b001, 1, 1, o(0, 0, 0, 4'h1, 1, 0));
    add("water3", 0, 0, 3'b000, 3, 1, o(0, 0, 0, 4'h1, 1, 0));
    add("cof_coin", 1, 0, 3'b000, 1, 1, o(1, 0, 0, 4'h2, 1, 0));
    add("coffee3", 0, 0, 3'b000, 3, 1, o(1, 0, 0, 4'h2, 1, 0));
    m3 = AC ? 0 : 1;
    add("done3", 0, 0, 3'b000, 1, 1, o(m3, AC ? 1 : 0, AC, 4'h0, 1, 0));
    add("idle3", 0, 0, 3'b000, 1, 1, o(m3, 0, 0, 4'h0, 0, 0));
    add("coin_to12", 1, 0, 3'b000, 12 - m3, 0, o(12, 0, 0, 4'h0, 0, 0));
    add("buy_coin", 1, 0, 3'b010, 1, 1, o(1, 0, 0, 4'h1, 1, 0));
    add("water4", 0, 0, 3'b000, 3, 1, o(1, 0, 0, 4'h1, 1, 0));
    add("coffee4", 0, 0, 3'b000, 4, 1, o(1, 0, 0, 4'h2, 1, 0));
    add("cream4", 0, 0, 3'b000, 4, 1, o(1, 0, 0, 4'h4, 1, 0));
    add("done4", 0, 0, 3'b000, 1, 1, o(m3, AC ? 1 : 0, AC, 4'h0, 1, 0));
    add("idle4", 0, 0, 3'b000, 1, 1, o(m3, 0, 0, 4'h0, 0, 0));
    p = m3 + 1;
    add("ins_coin", 1, 0, 3'b100, 1, 1, o(p, 0, 0, 4'h0, 0, 1));
    add("final", 0, 0, 3'b000, 1, 1, o(p, 0, 0, 4'h0, 0, 0));
    coin = 0; req = 0; click = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk0("reset_async");
    @(posedge clk);
    #1 chk0("reset_held");
    @(negedge clk);
    rst = 1'b0;
    run(0, 3);
    #2 rst = 1'b1;
    #1 chk0("reset_mid_water");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(0, seg_a);
    #2 rst = 1'b1;
    #1 chk0("reset_in_cream");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(seg_a, vecs.size());
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got=%0d pending want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
